// File: rtl/movavg_arb.sv
// Round-robin arbiter feeding a shared 4-tap moving-sum engine: each grant sums the
// new sample with that channel's three previous samples, then shifts the channel's history.
module movavg_arb #(
  parameter int NCH = 4,
  parameter int W   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*W-1:0]         din,
  output logic [NCH-1:0]           ack,
  output logic [W-1:0]             dout,
  output logic [$clog2(NCH)-1:0]   dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  input  logic                     clr,
  input  logic [$clog2(NCH)-1:0]   clr_ch,
  output logic                     busy
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    ADD3 = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t         state;
  logic [W-1:0]   tap1 [NCH];
  logic [W-1:0]   tap2 [NCH];
  logic [W-1:0]   tap3 [NCH];
  logic [W-1:0]   acc;
  logic [W-1:0]   sample;
  logic [CW-1:0]  g;
  logic [CW-1:0]  rr;

  logic           grant_found;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  rr_next;
  logic [W-1:0]   din_sel;
  logic [W-1:0]   operand;
  logic [W-1:0]   sum;
  int             idx;

  // Round-robin search: first requesting channel at or after rr, wrapping.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr) + k) % NCH;
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
  end

  assign rr_next = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
  assign din_sel = din[int'(grant_idx)*W +: W];

  // Single shared adder; the operand is the tap selected by the current ADD state.
  always_comb begin
    operand = '0;
    case (state)
      ADD1:    operand = tap1[g];
      ADD2:    operand = tap2[g];
      ADD3:    operand = tap3[g];
      default: operand = '0;
    endcase
  end

  assign sum = acc + operand;

  // ack is decided in the IDLE cycle itself so the grant and the load share one edge.
  always_comb begin
    ack        = '0;
    dout_valid = !reset && (state == OUT);
    busy       = !reset && (state != IDLE);
    dout       = dout_valid ? acc : '0;
    dout_ch    = dout_valid ? g : '0;
    if (!reset && state == IDLE && grant_found)
      ack = {{(NCH-1){1'b0}}, 1'b1} << grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      sample <= '0;
      g      <= '0;
      rr     <= '0;
      // NOTE: the tap history is architectural state and must be zeroed on reset,
      // so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < NCH; i++) begin
        tap1[i] <= '0;
        tap2[i] <= '0;
        tap3[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            acc    <= din_sel;
            sample <= din_sel;
            g      <= grant_idx;
            rr     <= rr_next;
            state  <= ADD1;
          end
        end
        ADD1: begin
          acc   <= sum;
          state <= ADD2;
        end
        ADD2: begin
          acc   <= sum;
          state <= ADD3;
        end
        ADD3: begin
          acc   <= sum;
          state <= OUT;
        end
        OUT: begin
          if (dout_ready) begin
            tap3[g] <= tap2[g];
            tap2[g] <= tap1[g];
            tap1[g] <= sample;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // NOTE: the last non-blocking assignment to a flop wins, so placing the clear
      // after the shift gives clr priority when both hit the same channel.
      if (clr && int'(clr_ch) < NCH) begin
        tap1[clr_ch] <= '0;
        tap2[clr_ch] <= '0;
        tap3[clr_ch] <= '0;
      end
    end
  end

endmodule

// File: doc/movavg_arb.md
MOVAVG_ARB -- requirements
Module: movavg_arb

Interface
REQ-001 Parameter NCH, default 4, number of requesting channels (2..8).
REQ-002 Parameter W, default 64, sample and result width in bits.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NCH  per-channel request; bit i high means din[i] holds a valid sample.
REQ-006 din  input  NCH*W  per-channel sample; channel i occupies bits [i*W +: W].
REQ-007 ack  output  NCH  one-hot, one-cycle pulse; the sample of the granted channel is consumed.
REQ-008 dout  output  W  4-tap sum for the served channel; 0 whenever dout_valid is low.
REQ-009 dout_ch  output  clog2(NCH)  channel index of dout; 0 whenever dout_valid is low.
REQ-010 dout_valid  output  1  result available.
REQ-011 dout_ready  input  1  downstream accepts the result.
REQ-012 clr  input  1  request to zero the tap history of channel clr_ch.
REQ-013 clr_ch  input  clog2(NCH)  channel selected by clr.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL keep three W-bit taps per channel (tap1 newest, tap3 oldest) and one shared accumulator, one shared W-bit adder and one sample register.
REQ-016 The FSM SHALL have the states IDLE, ADD1, ADD2, ADD3 and OUT, encoded in 3 bits.
REQ-017 IDLE: if any req bit is high, the block SHALL grant the channel g found by round-robin from pointer rr, pulse ack[g], load acc and the sample register with din[g], latch g and go to ADD1; otherwise it SHALL remain in IDLE.
REQ-018 Round-robin: the search SHALL start at rr and wrap modulo NCH; after each grant, rr SHALL become (g+1) mod NCH.
REQ-019 ADD1, ADD2 and ADD3 SHALL perform acc <= acc + tap1[g], acc + tap2[g] and acc + tap3[g] respectively, one state per cycle.
REQ-020 OUT: the block SHALL drive dout_valid=1, dout=acc and dout_ch=g, and hold them stable until dout_ready=1.
REQ-021 The OUT handshake (dout_valid & dout_ready) SHALL shift channel g: tap3<=tap2, tap2<=tap1, tap1<=sample register; the FSM SHALL then return to IDLE.
REQ-022 Latency: if ack is pulsed in cycle t, dout_valid SHALL first be high in cycle t+4; with dout_ready held high, the next grant SHALL occur no earlier than cycle t+5.
REQ-023 All additions SHALL be modulo 2^W; overflow SHALL wrap silently without a flag.
REQ-024 ack SHALL be asserted only in IDLE, at most one bit per cycle; req bits that are not granted SHALL remain pending with no side effect.
REQ-025 The taps of non-granted channels SHALL be unaffected by a transaction.
REQ-026 clr SHALL zero tap1..tap3 of channel clr_ch in the cycle following its assertion, in any FSM state.
REQ-027 If clr targets channel g in the same cycle as the OUT handshake, clr SHALL take priority and all three taps SHALL end at 0.
REQ-028 If clr targets channel g while the FSM is in ADD1..ADD3, additions that have already executed SHALL keep their values, and later additions SHALL use the cleared taps.
REQ-029 Deasserting req[g] after ack SHALL NOT affect the transaction in flight.

Reset
REQ-030 While reset is high, the FSM SHALL be forced to IDLE, all taps, acc and the sample register to 0, and rr to 0.
REQ-031 While reset is high, the outputs SHALL be ack=0, dout=0, dout_ch=0, dout_valid=0 and busy=0.
REQ-032 Reset asserted mid-transaction SHALL abort it: no dout_valid and no tap shift for that transaction.

Verification
REQ-033 After reset, req=0001 with din[0]=5: ack=0001 at t, dout_valid at t+4 with dout=5 and dout_ch=0; after the handshake, tap1[0]=5.
REQ-034 Channel 0 fed 1, 2, 3, 4, 10 on successive transactions: the fifth result SHALL be 10+4+3+2=19.
REQ-035 req=1111 held continuously with dout_ready=1: grants SHALL occur in the order 0,1,2,3,0 and each grant SHALL be 5 cycles apart.
REQ-036 dout_ready held low for 7 cycles in OUT: dout, dout_ch and dout_valid SHALL stay stable, no ack SHALL occur, and the FSM SHALL return to IDLE one cycle after dout_ready rises.
REQ-037 Channel 1 taps all 2^63 with din=2^63: dout SHALL equal 0 (wrap); clr with clr_ch=1 at the OUT handshake SHALL leave all channel 1 taps at 0.
REQ-038 reset pulsed while in ADD2: the next cycle SHALL show IDLE, dout_valid=0 and all taps 0, and the next grant SHALL start from channel 0.
